// File: rtl/multi_rate_divider.sv
// multi_rate_divider: NUM_CH independent programmable tick sources driven from one clock.
// Each channel counts its divisor down and emits a one-cycle tick at the end of every
// period (periodic mode) or once (one-shot mode). It also emits a phase output that
// toggles on each tick and a busy flag that is high while the channel is running.
//
// Ports:
//   clock     system clock, rising edge
//   resetn    synchronous active-low reset
//   cfg_we    configuration write strobe
//   cfg_ch    channel addressed by the write
//   cfg_div   new divisor (period in cycles, must be non-zero)
//   cfg_mode  0 = periodic, 1 = one-shot
//   ch_en     per-channel enable (level)
//   restart   per-channel reload strobe
//   tick      per-channel one-cycle pulse at end of period
//   phase     per-channel square wave, toggles on every tick
//   busy      per-channel RUN indicator
//   cfg_err   one-cycle pulse after a rejected write
module multi_rate_divider #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned DEFAULT_DIV = 6_250_000,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] restart,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] phase,
   output logic [NUM_CH-1:0] busy,
   output logic              cfg_err
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   logic wr_ok;
   logic err_q;

   // A write is only accepted for an existing channel and a non-zero divisor.
   assign wr_ok = cfg_we && (32'(cfg_ch) < NUM_CH) && (cfg_div != '0);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= cfg_we && !wr_ok;
      end
   end

   assign cfg_err = err_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_q;
      logic             mode_q;
      logic             tick_q, tick_d;
      logic             phase_q;
      logic             wr_hit;
      logic [CNT_W-1:0] ld_div;
      logic             ld_mode;

      // A write landing on this channel in the same cycle as a load takes effect
      // immediately, so the load sees the incoming divisor and mode.
      assign wr_hit  = wr_ok && (cfg_ch == CH_W'(c));
      assign ld_div  = wr_hit ? cfg_div : div_q;
      assign ld_mode = wr_hit ? cfg_mode : mode_q;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         tick_d  = 1'b0;
         if (!ch_en[c]) begin
            // Disabled: count is frozen and a pending end-of-period is dropped.
            state_d = StIdle;
         end else begin
            case (state_q)
               StIdle: begin
                  state_d = StRun;
                  cnt_d   = ld_div - CNT_W'(1);
               end
               StRun: begin
                  if (restart[c]) begin
                     cnt_d = ld_div - CNT_W'(1);
                  end else if (cnt_q != '0) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end else begin
                     tick_d = 1'b1;
                     if (ld_mode) begin
                        state_d = StDone;
                     end else begin
                        cnt_d = ld_div - CNT_W'(1);
                     end
                  end
               end
               StDone: begin
                  if (restart[c]) begin
                     state_d = StRun;
                     cnt_d   = ld_div - CNT_W'(1);
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end

      always_ff @(posedge clock) begin
         if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEFAULT_DIV);
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            phase_q <= phase_q ^ tick_d;
            if (wr_hit) begin
               div_q  <= cfg_div;
               mode_q <= cfg_mode;
            end
         end
      end

      assign tick[c]  = tick_q;
      assign phase[c] = phase_q;
      assign busy[c]  = (state_q == StRun);
   end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed testbench for multi_rate_divider with NUM_CH = 3, CNT_W = 8, DEFAULT_DIV = 4.
// Outputs are sampled on the falling edge; inputs change on the falling edge too, so
// they are sampled by the rising edge that ends the current cycle.
module tb_multi_rate_divider;

   localparam int unsigned NUM_CH      = 3;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned DEFAULT_DIV = 4;

   logic             clock = 1'b0;
   logic             resetn;
   logic             cfg_we;
   logic [1:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_mode;
   logic [2:0]       ch_en;
   logic [2:0]       restart;
   logic [2:0]       tick;
   logic [2:0]       phase;
   logic [2:0]       busy;
   logic             cfg_err;

   int         total = 0;
   int         bad   = 0;
   logic [2:0] phase_m;

   multi_rate_divider #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
   ) dut (
      .clock   (clock),
      .resetn  (resetn),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .cfg_mode(cfg_mode),
      .ch_en   (ch_en),
      .restart (restart),
      .tick    (tick),
      .phase   (phase),
      .busy    (busy),
      .cfg_err (cfg_err)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checks one cycle's outputs; the phase model flips on every expected tick.
   task automatic cyc_chk(input string tag, input int k, input logic [2:0] et,
                          input logic [2:0] eb, input logic ee);
      phase_m = phase_m ^ et;
      check_eq($sformatf("%s tick c%0d", tag, k), {29'b0, tick}, {29'b0, et});
      check_eq($sformatf("%s phase c%0d", tag, k), {29'b0, phase}, {29'b0, phase_m});
      check_eq($sformatf("%s busy c%0d", tag, k), {29'b0, busy}, {29'b0, eb});
      check_eq($sformatf("%s cfg_err c%0d", tag, k), {31'b0, cfg_err}, {31'b0, ee});
   endtask

   // Leaves resetn low at a falling edge; the caller releases it, making that cycle 0.
   task automatic do_reset(input logic [2:0] en);
      @(negedge clock);
      resetn  = 1'b0;
      ch_en   = en;
      cfg_we  = 1'b0;
      restart = 3'b000;
      repeat (2) @(negedge clock);
      phase_m = 3'b000;
      check_eq("reset tick", {29'b0, tick}, 32'd0);
      check_eq("reset phase", {29'b0, phase}, 32'd0);
      check_eq("reset busy", {29'b0, busy}, 32'd0);
      check_eq("reset cfg_err", {31'b0, cfg_err}, 32'd0);
   endtask

   function automatic bit tick_a(input int k);
      return k inside {5, 9, 13, 17, 20, 23, 26};
   endfunction

   function automatic bit tick_b(input int k);
      return (k inside {5, 9, 13, 17, 27, 32, 34, 36}) || (k >= 38 && k <= 42);
   endfunction

   function automatic bit busy_b(input int k);
      return (k >= 1 && k <= 42 && k != 21 && k != 22);
   endfunction

   initial begin
      resetn   = 1'b0;
      cfg_we   = 1'b0;
      cfg_ch   = 2'd0;
      cfg_div  = '0;
      cfg_mode = 1'b0;
      ch_en    = 3'b000;
      restart  = 3'b000;
      phase_m  = 3'b000;

      // A: default divisor on ch0, then a mid-period rewrite to 3.
      do_reset(3'b001);
      resetn = 1'b1;
      cyc_chk("A", 0, 3'b000, 3'b000, 1'b0);
      for (int k = 1; k <= 26; k++) begin
         @(negedge clock);
         cyc_chk("A", k, tick_a(k) ? 3'b001 : 3'b000, 3'b001, 1'b0);
         if (k == 14) begin
            cfg_we   = 1'b1;
            cfg_ch   = 2'd0;
            cfg_div  = 8'd3;
            cfg_mode = 1'b0;
         end else begin
            cfg_we = 1'b0;
         end
      end

      // C: one-shot on ch1 with div 5, then a restart.
      do_reset(3'b000);
      resetn   = 1'b1;
      cfg_we   = 1'b1;
      cfg_ch   = 2'd1;
      cfg_div  = 8'd5;
      cfg_mode = 1'b1;
      cyc_chk("C", 0, 3'b000, 3'b000, 1'b0);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clock);
         cyc_chk("C", k, (k == 7 || k == 19) ? 3'b010 : 3'b000,
                 ((k >= 2 && k <= 6) || (k >= 14 && k <= 18)) ? 3'b010 : 3'b000, 1'b0);
         cfg_we  = 1'b0;
         restart = (k == 13) ? 3'b010 : 3'b000;
         if (k == 1) ch_en = 3'b010;
      end

      // B: rejected writes, disable at cnt == 0, bypassed restart, div 1, mid-run reset.
      do_reset(3'b001);
      resetn = 1'b1;
      cyc_chk("B", 0, 3'b000, 3'b000, 1'b0);
      for (int k = 1; k <= 43; k++) begin
         @(negedge clock);
         if (k == 43) phase_m = 3'b000;
         cyc_chk("B", k, tick_b(k) ? 3'b001 : 3'b000, busy_b(k) ? 3'b001 : 3'b000,
                 (k == 3 || k == 6));
         cfg_we  = 1'b0;
         restart = 3'b000;
         case (k)
            2: begin
               cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7; cfg_mode = 1'b0;
            end
            5: begin
               cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b1;
            end
            20: ch_en = 3'b000;
            22: ch_en = 3'b001;
            29: begin
               restart = 3'b001;
               cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; cfg_mode = 1'b0;
            end
            36: begin
               restart = 3'b001;
               cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; cfg_mode = 1'b0;
            end
            42: resetn = 1'b0;
            default: ;
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_rate_divider.md
# multi_rate_divider

Parametrised, multi-channel successor to the single-rate 8 Hz divider and two-cycle delay counter. It supplies independent programmable tick sources (game-logic step, animation, input debounce, short delays) from the 50 MHz system clock. Each channel has a runtime-writable divisor, periodic or one-shot mode, enable and restart controls. Each channel produces a one-cycle tick, a toggling phase output and a busy flag.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 26, divisor/counter width in bits
- DEFAULT_DIV, 6_250_000, divisor loaded at reset into every channel (8 Hz at 50 MHz); must be 1..2^CNT_W-1
- CH_W (derived, not overridable), max(1, clog2(NUM_CH)), channel-select width

- clock  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- cfg_we  in  1  configuration write strobe, sampled every cycle
- cfg_ch  in  CH_W  channel addressed by the write
- cfg_div  in  CNT_W  new divisor (period in clock cycles)
- cfg_mode  in  1  0 = periodic, 1 = one-shot
- ch_en  in  NUM_CH  per-channel enable, level-sensitive
- restart  in  NUM_CH  per-channel reload strobe
- tick  out  NUM_CH  one-cycle pulse at end of each period
- phase  out  NUM_CH  toggles on every tick (square wave at half tick rate)
- busy  out  NUM_CH  channel in RUN state
- cfg_err  out  1  one-cycle pulse: last write rejected

## Operation
- Per-channel state:
  - div register, mode register
  - down-counter cnt[CNT_W-1:0]
  - FSM with states IDLE, RUN, DONE
- Reset values:
  - state = IDLE, cnt = 0, div = DEFAULT_DIV, mode = periodic
  - tick = 0, phase = 0, busy = 0, cfg_err = 0
- FSM priority per channel, highest first: ch_en low, then restart, then counting.
  - ch_en = 0: next state IDLE. cnt is held. No tick, even if cnt == 0 this cycle.
  - IDLE with ch_en = 1: load cnt = div - 1 and go to RUN. The restart input is irrelevant here.
  - RUN with restart = 1: load cnt = div - 1 and stay in RUN. No tick that cycle, even if cnt == 0.
  - RUN with cnt != 0: decrement cnt.
  - RUN with cnt == 0: tick = 1 next cycle and phase toggles.
    - Periodic: reload cnt = div - 1 and stay in RUN.
    - One-shot: go to DONE.
  - DONE: hold. restart = 1 loads cnt = div - 1 and goes to RUN. ch_en = 0 goes to IDLE.
- busy = (state == RUN), registered with the state.
- Configuration writes:
  - Accepted when cfg_we = 1, cfg_ch < NUM_CH and cfg_div != 0. The addressed channel's div and mode update at the clock edge.
  - Otherwise the write is rejected: cfg_err = 1 next cycle and no register changes.
  - A running count is not disturbed. The new div applies at the next load (reload, restart, or IDLE exit).
  - Write and load on the same channel in the same cycle: the load uses cfg_div/cfg_mode being written (bypass).
- Arithmetic:
  - Counter is unsigned CNT_W bits and never wraps. The decrement only occurs when cnt != 0.
  - div = 1 gives cnt = 0 permanently: tick on every cycle in periodic mode.
- Channels are fully independent. Simultaneous ticks on several channels are allowed.

## Timing
- Load at edge ending cycle t (IDLE exit or restart): first tick is high during cycle t + div + 1.
- Periodic spacing between ticks: exactly div cycles. tick is high for exactly 1 cycle (except div = 1, where it is continuously high).
- One-shot: exactly one tick, in cycle t + div + 1. busy is low from that same cycle.
- cfg_err: high during the cycle after the rejected write, for 1 cycle.
- Reset mid-operation: all outputs reach reset values in the cycle after resetn is sampled low, regardless of state. Channels with ch_en = 1 load cnt = DEFAULT_DIV - 1 on the first cycle with resetn = 1.
- No combinational path from any input to any output.

## Test plan
- Bench uses NUM_CH = 3, CNT_W = 8, DEFAULT_DIV = 4.
- Reset, ch_en = 3'b001 held -> tick[0] high in cycles 5, 9, 13 after reset release; phase[0] reads 1, 0, 1 after each; busy[0] = 1 from cycle 1; channels 1 and 2 silent.
- ch0 running at div 4; write cfg_ch = 0, cfg_div = 3, cfg_mode = 0 mid-period -> current period completes at 4 cycles, subsequent ticks 3 cycles apart.
- Write ch1 cfg_div = 5, cfg_mode = 1, then ch_en[1] = 1 at cycle t -> single tick[1] at t + 6; busy[1] falls at t + 6; no further ticks. restart[1] pulse -> one more tick 6 cycles later.
- Writes cfg_ch = 3 and cfg_ch = 0 with cfg_div = 0 -> cfg_err pulses once for each; ch0 period unchanged at 4.
- ch_en[0] dropped in the cycle cnt == 0 -> no tick, busy low next cycle. Re-enable -> first tick a full div + 1 cycles later. restart together with a cfg write of div = 2 on ch0 -> next tick after 3 cycles.
- cfg_div = 1 periodic -> tick continuously high, phase toggles every cycle. Assert resetn = 0 mid-run -> tick, phase, busy all 0 next cycle.
